// File: rtl/lenet_sequencer.sv
// rtl/lenet_sequencer.sv - frame controller for the LeNet layer engines
// Launches each stage in turn with a hang watchdog, then picks the clamped argmax class.
module lenet_sequencer #(
  parameter int BITWIDTH       = 8,
  parameter int NUM_STAGES     = 4,
  parameter int NUM_CLASSES    = 10,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic [NUM_STAGES-1:0]  stage_start,
  input  logic [NUM_STAGES-1:0]  stage_done,
  output logic [3:0]             score_index,
  input  logic [BITWIDTH-1:0]    score_data,
  output logic                   busy,
  output logic                   done,
  output logic                   error,
  output logic [3:0]             class_out,
  output logic [NUM_CLASSES-1:0] led
);

  localparam int              KW           = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [KW-1:0]   LAST_STAGE   = KW'(NUM_STAGES - 1);
  localparam logic [3:0]      LAST_CLASS   = 4'(NUM_CLASSES - 1);
  localparam logic [15:0]     TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT,
    S_SCAN,
    S_DONE
  } state_t;

  state_t                 state, state_nxt;
  logic [KW-1:0]          stage, stage_nxt;
  logic [15:0]            timer, timer_nxt;
  logic [3:0]             idx, idx_nxt;
  logic [BITWIDTH-1:0]    best, best_nxt;
  logic [3:0]             best_idx, best_idx_nxt;
  logic                   error_nxt;
  logic [3:0]             class_nxt;
  logic [NUM_CLASSES-1:0] led_nxt;

  // Negative scores count as zero, so an all-negative vector resolves to class 0.
  logic [BITWIDTH-1:0]    clamped;
  logic                   take;

  assign clamped = score_data[BITWIDTH-1] ? '0 : score_data;
  assign take    = (clamped > best);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      stage     <= '0;
      timer     <= '0;
      idx       <= '0;
      best      <= '0;
      best_idx  <= '0;
      error     <= 1'b0;
      class_out <= '0;
      led       <= '0;
    end else begin
      state     <= state_nxt;
      stage     <= stage_nxt;
      timer     <= timer_nxt;
      idx       <= idx_nxt;
      best      <= best_nxt;
      best_idx  <= best_idx_nxt;
      error     <= error_nxt;
      class_out <= class_nxt;
      led       <= led_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    stage_nxt    = stage;
    timer_nxt    = timer;
    idx_nxt      = idx;
    best_nxt     = best;
    best_idx_nxt = best_idx;
    error_nxt    = error;
    class_nxt    = class_out;
    led_nxt      = led;
    stage_start  = '0;
    busy         = (state != S_IDLE);
    done         = 1'b0;
    score_index  = 4'd0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_LAUNCH;
          stage_nxt = '0;
          timer_nxt = '0;
          error_nxt = 1'b0;
        end
      end
      S_LAUNCH: begin
        stage_start = NUM_STAGES'(1) << stage;
        timer_nxt   = '0;
        state_nxt   = S_WAIT;
      end
      S_WAIT: begin
        // Completion wins over the watchdog when both land in the same cycle.
        if (stage_done[stage]) begin
          if (stage == LAST_STAGE) begin
            idx_nxt      = '0;
            best_nxt     = '0;
            best_idx_nxt = '0;
            state_nxt    = S_SCAN;
          end else begin
            stage_nxt = stage + KW'(1);
            state_nxt = S_LAUNCH;
          end
        end else if (timer == TIMEOUT_LAST) begin
          error_nxt = 1'b1;
          state_nxt = S_IDLE;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end
      S_SCAN: begin
        score_index = idx;
        if (take) begin
          best_nxt     = clamped;
          best_idx_nxt = idx;
        end
        if (idx == LAST_CLASS) begin
          class_nxt = take ? idx : best_idx;
          led_nxt   = NUM_CLASSES'(1) << class_nxt;
          state_nxt = S_DONE;
        end else begin
          idx_nxt = idx + 4'd1;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase

    // Abort drops the frame without touching the sticky/latched results.
    if (abort && (state != S_IDLE)) begin
      state_nxt   = S_IDLE;
      stage_start = '0;
      busy        = 1'b0;
      error_nxt   = error;
      class_nxt   = class_out;
      led_nxt     = led;
    end
  end

endmodule

// File: doc/lenet_sequencer.md
# lenet_sequencer

Frame-level controller for the LeNet accelerator datapath. It launches the layer engines (conv1, conv2, conv3, fully-connected) one at a time on a start/done handshake and watches each for a hang. After the last layer it scans the 10-entry output vector serially, applying the same negative-clamped argmax policy as the board top. It latches the winning class and the one-hot LED pattern and pulses `done`.

## Interface
- `BITWIDTH`, 8, width of signed score words
- `NUM_STAGES`, 4, number of sequenced layer engines
- `NUM_CLASSES`, 10, output vector length (≤16)
- `TIMEOUT_CYCLES`, 65535, max cycles a stage may run before abort (16-bit counter)

- `clk` in 1, single clock, all logic on rising edge
- `reset` in 1, asynchronous, active-low; clears all state
- `start` in 1, request one frame; sampled only in IDLE
- `abort` in 1, cancel current frame; no `done` pulse
- `stage_start` out NUM_STAGES, one-hot single-cycle launch pulse to stage k
- `stage_done` in NUM_STAGES, stage k completion level/pulse
- `score_index` out 4, output vector entry being read
- `score_data` in BITWIDTH, signed score for `score_index`, same-cycle (combinational read)
- `busy` out 1, high from LAUNCH of stage 0 through DONE
- `done` out 1, one-cycle completion pulse
- `error` out 1, stage timeout flag, sticky until next accepted `start`
- `class_out` out 4, latched winning class
- `led` out NUM_CLASSES, latched one-hot of `class_out`

## Operation
- States: IDLE, LAUNCH, WAIT, SCAN, DONE.
- IDLE: when `start`=1, go to LAUNCH with k=0. This also clears `error` and the timeout counter. If `start` arrives in any other state, it is ignored.
- LAUNCH: `stage_start[k]`=1 for this cycle only. Clear the timeout counter and go to WAIT.
- WAIT:
  - Only `stage_done[k]` is observed; all other `stage_done` bits are ignored. `stage_done[k]` asserted during LAUNCH is also ignored.
  - On `stage_done[k]`=1: if k<NUM_STAGES-1, set k+1 and go to LAUNCH. Otherwise set scan index i=0, best=0, best_idx=0 and go to SCAN.
  - The counter increments every WAIT cycle. When it equals TIMEOUT_CYCLES-1 without `stage_done[k]`, set `error`=1 and go to IDLE. `done` is not pulsed, and `class_out`/`led` are unchanged.
- SCAN: `score_index`=i.
  - v = `score_data` if its MSB is 0, else 0 (clamp negatives).
  - If v > best (strictly greater, unsigned after clamp), update best=v and best_idx=i. Ties keep the lower index. Entry 0 seeds best with no compare.
  - i increments each cycle. After i=NUM_CLASSES-1, go to DONE.
- DONE:
  - `class_out` = best_idx; `led` = 1<<best_idx; `done`=1 for this one cycle.
  - Return to IDLE.
- `abort`=1 in any non-IDLE state: next state IDLE. Outputs behave as follows:
  - `stage_start` = 0.
  - `busy` = 0.
  - `error`, `class_out`, `led` unchanged.
- `abort` has priority over `stage_done` and timeout in the same cycle. `stage_done` has priority over timeout in the same cycle.
- `score_index` = 0 outside SCAN.

## Timing
- Reset values: `stage_start`=0, `busy`=0, `done`=0, `error`=0, `score_index`=0, `class_out`=0, `led`=0; state IDLE, k=0.
- Reset asserted mid-frame: outputs go to reset values immediately (asynchronous). The frame is lost, and no `done` pulse is issued.
- `start` high in cycle 0 (IDLE) → `stage_start[0]` and `busy` high in cycle 1.
- Stage k with `stage_done` first high D_k ≥ 1 cycles after its `stage_start` occupies D_k+1 cycles.
- `done` high in cycle 1 + Σ(D_k+1) + NUM_CLASSES. `busy` drops the cycle after `done`.
- `start` held high continuously gives back-to-back frames: the next `stage_start[0]` comes 2 cycles after `done`.
- `class_out`/`led` change only in DONE, so they are stable for an entire frame.

## Test plan
- Nominal run:
  - Stimulus: all stages with D=3; scores {−5,12,40,7,40,0,−128,3,39,1}.
  - Required: `stage_start` pulses in cycles 1, 5, 9, 13; `done` in cycle 27; `class_out`=2 (tie with 6→ no, tie with index 4 keeps 2); `led`=10'b0000000100.
- All-negative scores:
  - Stimulus: every `score_data`=−1.
  - Required: `class_out`=0; `led`=10'b0000000001.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=16; stage 2 never answers.
  - Required: `error`=1 and return to IDLE exactly 16 WAIT cycles after `stage_start[2]`; no `done`; prior `class_out` kept. The next `start` clears `error`.
- Abort and spurious done:
  - Stimulus: `abort` in the same cycle as `stage_done[1]` during stage 1.
  - Required: IDLE next cycle; `stage_start[2]` never issued; `busy`=0.
  - Stimulus: `stage_done[3]` asserted while waiting on stage 0.
  - Required: ignored.
- Reset mid-SCAN:
  - Stimulus: drive `reset` low while `score_index`=5.
  - Required: all outputs 0 immediately. After release, `start` runs a full frame normally.
- Back-to-back with `start` held:
  - Stimulus: hold `start` high continuously.
  - Required: the second frame's `stage_start[0]` comes 2 cycles after the first `done`. A `start` pulse during SCAN has no effect.
